caf_peak_select: RTL and testbench

//  Downstream of arg_max: consumes one (out_max, index) result per Doppler/frequency bin
//  and reduces a frame of FREQ_BINS results to the global CAF peak.

---
 rtl/caf_peak_select.sv | 138 +++++++++++++
 tb/tb_caf_peak_select.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/caf_peak_select.sv
// Reduces one frame of FREQ_BINS arg_max results to the global CAF peak.
// Outputs magnitude, lag index, frequency bin and a threshold-detect flag.
module caf_peak_select #(
   parameter int unsigned MAX_BITS   = 24,
   parameter int unsigned INDEX_BITS = 10,
   parameter int unsigned FREQ_BINS  = 16,
   parameter int unsigned FREQ_BITS  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  m_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [MAX_BITS-1:0]   in_max,
   input  logic [INDEX_BITS-1:0] in_index,
   input  logic [MAX_BITS-1:0]   threshold,
   output logic                  s_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [MAX_BITS-1:0]   peak_max,
   output logic [INDEX_BITS-1:0] peak_index,
   output logic [FREQ_BITS-1:0]  peak_freq,
   output logic                  detect
);

   localparam logic [0:0] StAccum = 1'b0;
   localparam logic [0:0] StHold  = 1'b1;

   localparam logic [FREQ_BITS-1:0] LastBin = FREQ_BITS'(FREQ_BINS - 1);

   logic [0:0]            state_q, state_d;
   logic [FREQ_BITS-1:0]  bin_cnt_q, bin_cnt_d;
   logic [MAX_BITS-1:0]   best_max_q, best_max_d;
   logic [INDEX_BITS-1:0] best_index_q, best_index_d;
   logic [FREQ_BITS-1:0]  best_freq_q, best_freq_d;
   logic                  tready_q, tready_d;
   logic                  tvalid_q, tvalid_d;
   logic [MAX_BITS-1:0]   peak_max_q, peak_max_d;
   logic [INDEX_BITS-1:0] peak_index_q, peak_index_d;
   logic [FREQ_BITS-1:0]  peak_freq_q, peak_freq_d;
   logic                  detect_q, detect_d;

   logic                  accept;
   logic                  new_best;
   logic [MAX_BITS-1:0]   cand_max;
   logic [INDEX_BITS-1:0] cand_index;
   logic [FREQ_BITS-1:0]  cand_freq;

   assign accept = m_axis_tvalid & tready_q;

   // Strict compare: on equal magnitude the earlier (lower) bin is kept.
   assign new_best   = (bin_cnt_q == '0) || (in_max > best_max_q);
   assign cand_max   = new_best ? in_max    : best_max_q;
   assign cand_index = new_best ? in_index  : best_index_q;
   assign cand_freq  = new_best ? bin_cnt_q : best_freq_q;

   always_comb begin
      state_d      = state_q;
      bin_cnt_d    = bin_cnt_q;
      best_max_d   = best_max_q;
      best_index_d = best_index_q;
      best_freq_d  = best_freq_q;
      tready_d     = tready_q;
      tvalid_d     = tvalid_q;
      peak_max_d   = peak_max_q;
      peak_index_d = peak_index_q;
      peak_freq_d  = peak_freq_q;
      detect_d     = detect_q;

      if (clear) begin
         state_d   = StAccum;
         bin_cnt_d = '0;
         tvalid_d  = 1'b0;
         tready_d  = 1'b1;
      end else if (state_q == StAccum) begin
         tready_d = 1'b1;
         if (accept) begin
            best_max_d   = cand_max;
            best_index_d = cand_index;
            best_freq_d  = cand_freq;
            if (bin_cnt_q == LastBin) begin
               bin_cnt_d    = '0;
               state_d      = StHold;
               tvalid_d     = 1'b1;
               tready_d     = 1'b0;
               peak_max_d   = cand_max;
               peak_index_d = cand_index;
               peak_freq_d  = cand_freq;
               detect_d     = (cand_max >= threshold);
            end else begin
               bin_cnt_d = bin_cnt_q + 1'b1;
            end
         end
      end else begin
         // Holding a result: only the downstream handshake moves us on.
         if (tvalid_q && m_axis_tready) begin
            state_d  = StAccum;
            tvalid_d = 1'b0;
            tready_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StAccum;
         bin_cnt_q    <= '0;
         best_max_q   <= '0;
         best_index_q <= '0;
         best_freq_q  <= '0;
         tready_q     <= 1'b0;
         tvalid_q     <= 1'b0;
         peak_max_q   <= '0;
         peak_index_q <= '0;
         peak_freq_q  <= '0;
         detect_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         bin_cnt_q    <= bin_cnt_d;
         best_max_q   <= best_max_d;
         best_index_q <= best_index_d;
         best_freq_q  <= best_freq_d;
         tready_q     <= tready_d;
         tvalid_q     <= tvalid_d;
         peak_max_q   <= peak_max_d;
         peak_index_q <= peak_index_d;
         peak_freq_q  <= peak_freq_d;
         detect_q     <= detect_d;
      end
   end

   assign s_axis_tready = tready_q;
   assign s_axis_tvalid = tvalid_q;
   assign peak_max      = peak_max_q;
   assign peak_index    = peak_index_q;
   assign peak_freq     = peak_freq_q;
   assign detect        = detect_q;

endmodule

// File: tb/tb_caf_peak_select.sv
// Directed bench for caf_peak_select: frames are driven beat by beat, expected
// peaks are queued when a frame is sent and compared when the result appears.
module tb_caf_peak_select;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        m_axis_tvalid;
   logic        s_axis_tready;
   logic [23:0] in_max;
   logic [9:0]  in_index;
   logic [23:0] threshold;
   logic        s_axis_tvalid;
   logic        m_axis_tready;
   logic [23:0] peak_max;
   logic [9:0]  peak_index;
   logic [3:0]  peak_freq;
   logic        detect;

   typedef struct packed {
      logic [23:0] m;
      logic [9:0]  i;
      logic [3:0]  f;
      logic        d;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [23:0] fr_max[16];
   logic [9:0]  fr_idx[16];
   logic [23:0] last_max;

   caf_peak_select #(
      .MAX_BITS  (24),
      .INDEX_BITS(10),
      .FREQ_BINS (16),
      .FREQ_BITS (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .m_axis_tvalid(m_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .in_max       (in_max),
      .in_index     (in_index),
      .threshold    (threshold),
      .s_axis_tvalid(s_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .peak_max     (peak_max),
      .peak_index   (peak_index),
      .peak_freq    (peak_freq),
      .detect       (detect)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [23:0] m, input logic [9:0] i, input logic [3:0] f,
                           input logic d);
      exp_t e;
      e.m = m; e.i = i; e.f = f; e.d = d;
      sb.push_back(e);
   endtask

   // Reference reduction over fr_* with the current threshold.
   task automatic push_model();
      exp_t e;
      e.m = fr_max[0]; e.i = fr_idx[0]; e.f = 4'd0;
      for (int b = 1; b < 16; b++) begin
         if (fr_max[b] > e.m) begin
            e.m = fr_max[b]; e.i = fr_idx[b]; e.f = 4'(b);
         end
      end
      e.d = (e.m >= threshold);
      sb.push_back(e);
   endtask

   task automatic send_beat(input logic [23:0] mx, input logic [9:0] ix, input int gap);
      int n;
      int idle;
      idle = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
      m_axis_tvalid = 1'b0;
      for (int k = 0; k < idle; k++) tick();
      m_axis_tvalid = 1'b1;
      in_max        = mx;
      in_index      = ix;
      n = 0;
      while (!s_axis_tready && n < 50) begin
         tick();
         n++;
      end
      if (!s_axis_tready) check("tready_timeout", 64'd0, 64'd1);
      tick();
      m_axis_tvalid = 1'b0;
   endtask

   task automatic send_beats(input int count, input int gap);
      for (int b = 0; b < count; b++) send_beat(fr_max[b], fr_idx[b], gap);
   endtask

   task automatic send_frame(input int gap);
      send_beats(16, gap);
      check("latency_tvalid", 64'(s_axis_tvalid), 64'd1);
   endtask

   task automatic collect();
      int   n;
      exp_t e;
      n = 0;
      while (!s_axis_tvalid && n < 50) begin
         tick();
         n++;
      end
      if (!s_axis_tvalid) begin
         check("result_timeout", 64'd0, 64'd1);
         return;
      end
      if (sb.size() == 0) begin
         check("unexpected_result", 64'd0, 64'd1);
         return;
      end
      e = sb.pop_front();
      check("peak_max",   64'(peak_max),   64'(e.m));
      check("peak_index", 64'(peak_index), 64'(e.i));
      check("peak_freq",  64'(peak_freq),  64'(e.f));
      check("detect",     64'(detect),     64'(e.d));
      check("tready_in_hold", 64'(s_axis_tready), 64'd0);
      last_max = peak_max;
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
      check("tvalid_after_hs", 64'(s_axis_tvalid), 64'd0);
      check("tready_after_hs", 64'(s_axis_tready), 64'd1);
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; m_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
      in_max = '0; in_index = '0; threshold = '0;
      #1;
      check("rst_tready", 64'(s_axis_tready), 64'd0);
      check("rst_tvalid", 64'(s_axis_tvalid), 64'd0);
      check("rst_peak_max", 64'(peak_max), 64'd0);
      check("rst_detect", 64'(detect), 64'd0);
      #16 reset = 1'b0;
      #1 check("tready_before_edge", 64'(s_axis_tready), 64'd0);
      tick();
      check("tready_after_rst", 64'(s_axis_tready), 64'd1);

      // Ramp: the last bin is the peak.
      threshold = 24'd200;
      for (int b = 0; b < 16; b++) begin fr_max[b] = 24'(b * 10); fr_idx[b] = 10'(b); end
      push_exp(24'd150, 10'd15, 4'd15, 1'b0);
      send_frame(0);
      collect();

      // Tie between bins 3 and 9: earliest wins.
      threshold = 24'd0;
      for (int b = 0; b < 16; b++) begin fr_max[b] = 24'd1; fr_idx[b] = 10'(b * 2); end
      fr_max[3] = 24'd500; fr_max[9] = 24'd500;
      push_exp(24'd500, 10'd6, 4'd3, 1'b1);
      send_frame(0);
      collect();

      // Downstream stall: result held, extra upstream beats refused.
      for (int b = 0; b < 16; b++) begin fr_max[b] = 24'(b * 3 + 1); fr_idx[b] = 10'(b); end
      push_exp(24'd46, 10'd15, 4'd15, 1'b1);
      send_frame(0);
      m_axis_tvalid = 1'b1; in_max = 24'd60000; in_index = 10'd7;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("stall_tready", 64'(s_axis_tready), 64'd0);
         check("stall_tvalid", 64'(s_axis_tvalid), 64'd1);
         check("stall_peak_max", 64'(peak_max), 64'd46);
      end
      m_axis_tvalid = 1'b0;
      collect();
      for (int b = 0; b < 16; b++) begin fr_max[b] = 24'(777 - b); fr_idx[b] = 10'(b + 40); end
      push_exp(24'd777, 10'd40, 4'd0, 1'b1);
      send_frame(0);
      collect();

      // Threshold boundary.
      for (int b = 0; b < 16; b++) begin fr_max[b] = 24'd5; fr_idx[b] = 10'(b + 100); end
      fr_max[6] = 24'd1000;
      threshold = 24'd1000;
      push_exp(24'd1000, 10'd106, 4'd6, 1'b1);
      send_frame(0);
      collect();
      threshold = 24'd1001;
      push_exp(24'd1000, 10'd106, 4'd6, 1'b0);
      send_frame(0);
      collect();

      // Clear after 7 bins, with a competing beat in the clear cycle.
      for (int b = 0; b < 16; b++) begin fr_max[b] = 24'd5000; fr_idx[b] = 10'd999; end
      send_beats(7, 0);
      clear = 1'b1; m_axis_tvalid = 1'b1; in_max = 24'd9999; in_index = 10'd1;
      tick();
      clear = 1'b0; m_axis_tvalid = 1'b0;
      check("clear_tready", 64'(s_axis_tready), 64'd1);
      check("clear_tvalid", 64'(s_axis_tvalid), 64'd0);
      check("clear_peak_kept", 64'(peak_max), 64'(last_max));
      threshold = 24'd30;
      for (int b = 0; b < 16; b++) begin fr_max[b] = 24'(b + 20); fr_idx[b] = 10'(b + 300); end
      fr_max[11] = 24'd90;
      push_model();
      send_frame(0);
      collect();

      // Asynchronous reset mid-frame.
      send_beats(5, 0);
      #3 reset = 1'b1;
      #1;
      check("mid_rst_tready", 64'(s_axis_tready), 64'd0);
      check("mid_rst_tvalid", 64'(s_axis_tvalid), 64'd0);
      check("mid_rst_peak_max", 64'(peak_max), 64'd0);
      check("mid_rst_peak_index", 64'(peak_index), 64'd0);
      check("mid_rst_peak_freq", 64'(peak_freq), 64'd0);
      check("mid_rst_detect", 64'(detect), 64'd0);
      #2 reset = 1'b0;
      #1 check("mid_rst_tready_hold", 64'(s_axis_tready), 64'd0);
      tick();
      check("mid_rst_tready_up", 64'(s_axis_tready), 64'd1);

      // Random data, gapless then with random gaps.
      threshold = 24'h400000;
      for (int b = 0; b < 16; b++) begin
         fr_max[b] = 24'($urandom_range(0, 24'hFFFFFF));
         fr_idx[b] = 10'($urandom_range(0, 1023));
      end
      push_model();
      send_frame(0);
      collect();
      push_model();
      send_frame(3);
      collect();

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
